// File: rtl/fetch_unit.sv
// Instruction fetch: requests the word at PC and holds it for decode until that stage completes it.
// Latency: Instr/instr_valid are registered one cycle after imem_ack; peak rate is one instruction per two cycles.
// Backpressure: instr_ready=0 freezes Instr/PC/instr_valid and no new request is issued.
// Optional fetch timeout: define FETCH_TIMEOUT_EN to enable the S_ERR path (sticky fetch_err).
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] pc_target,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        timeout_hit;

    // A zero timeout would flag an error before any memory could answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // Count consecutive unanswered request cycles; any ack or leaving S_REQ restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == S_REQ && !imem_ack) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // This cycle is the last allowed unanswered one.
    assign timeout_hit = (state == S_REQ) && !imem_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register; reset overrides any ack/ready seen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: ack ends the request, ready releases the held word, S_ERR is terminal.
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (imem_ack) begin
                    state_nxt = S_HOLD;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_nxt = S_REQ;
                end
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_REQ;
        endcase
    end

    // Outputs decoded from state: request only while fetching, error flag only in S_ERR.
    always_comb begin
        imem_req  = (state == S_REQ);
`ifdef FETCH_TIMEOUT_EN
        fetch_err = (state == S_ERR);
`else
        fetch_err = 1'b0;
`endif
    end

    // Datapath: capture the word on ack, advance PC (branch target is forced word-aligned) on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        pc_q    <= PCSrc ? (pc_target & 32'hFFFF_FFFC) : (pc_q + 32'd4);
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PCPlus8     = pc_q + 32'd8;
    assign Instr       = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int          TMO     = 16;
`ifdef FETCH_TIMEOUT_EN
    localparam bit          TMO_EN  = 1'b1;
`else
    localparam bit          TMO_EN  = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] pc_target;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCSrc       (PCSrc),
        .pc_target   (pc_target),
        .PC          (PC),
        .PCPlus8     (PCPlus8),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is either being fetched, held for decode, or the unit is dead.
    bit          m_init    = 1'b0;
    bit          m_holding = 1'b0;
    bit          m_dead    = 1'b0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_instr   = 32'h0;
    int          m_wait    = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_init    = 1'b1;
            m_holding = 1'b0;
            m_dead    = 1'b0;
            m_pc      = RST_PC;
            m_instr   = 32'h0;
            m_wait    = 0;
        end else if (m_dead) begin
            m_wait = 0;
        end else if (!m_holding) begin
            if (imem_ack) begin
                m_instr   = imem_rdata;
                m_holding = 1'b1;
                m_wait    = 0;
            end else begin
                m_wait = m_wait + 1;
                if (TMO_EN && m_wait >= TMO) m_dead = 1'b1;
            end
        end else if (instr_ready) begin
            if (PCSrc) m_pc = {pc_target[31:2], 2'b00};
            else       m_pc = m_pc + 32'd4;
            m_holding = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("m_req",   {31'b0, imem_req},    {31'b0, (!m_holding && !m_dead)});
            chk("m_addr",  imem_addr,            m_pc);
            chk("m_valid", {31'b0, instr_valid}, {31'b0, m_holding});
            chk("m_instr", Instr,                m_instr);
            chk("m_pc",    PC,                   m_pc);
            chk("m_pc8",   PCPlus8,              m_pc + 32'd8);
            chk("m_err",   {31'b0, fetch_err},   {31'b0, m_dead});
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        pc_target   = 32'h0;
        tick;
        tick;

        // Reset state
        chk("rst_req",   {31'b0, imem_req},    32'd1);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", Instr,                32'h0);
        chk("rst_err",   {31'b0, fetch_err},   32'd0);
        reset = 1'b0;

        // First fetch: ack in the first request cycle
        imem_ack = 1'b1; imem_rdata = 32'hE3A0_0001;
        tick;
        imem_ack = 1'b0;
        chk("f1_instr", Instr,                32'hE3A0_0001);
        chk("f1_valid", {31'b0, instr_valid}, 32'd1);
        chk("f1_pc",    PC,                   32'h0);
        chk("f1_pc8",   PCPlus8,              32'h8);
        chk("f1_req",   {31'b0, imem_req},    32'd0);

        // Branch to 0x10, then sequential to 0x14, then branch to misaligned 0x103 -> 0x100
        instr_ready = 1'b1; PCSrc = 1'b1; pc_target = 32'h10;
        tick;
        instr_ready = 1'b0; PCSrc = 1'b0;
        chk("br10_addr", imem_addr, 32'h10);
        imem_ack = 1'b1; imem_rdata = 32'hE281_1001;
        tick;
        imem_ack = 1'b0; instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("seq14_addr", imem_addr, 32'h14);
        imem_ack = 1'b1; imem_rdata = 32'hE1A0_F00E;
        tick;
        imem_ack = 1'b0; instr_ready = 1'b1; PCSrc = 1'b1; pc_target = 32'h103;
        tick;
        instr_ready = 1'b0; PCSrc = 1'b0;
        chk("br100_addr", imem_addr, 32'h100);

        // Ack delayed 5 cycles; branch inputs driven meanwhile must be ignored
        PCSrc = 1'b1; pc_target = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("dly_req",   {31'b0, imem_req},    32'd1);
            chk("dly_addr",  imem_addr,            32'h100);
            chk("dly_valid", {31'b0, instr_valid}, 32'd0);
        end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick;
        imem_ack = 1'b0; PCSrc = 1'b0;
        chk("dly_valid1", {31'b0, instr_valid}, 32'd1);
        chk("dly_instr",  Instr,                32'h1234_5678);

        // Held for 4 cycles with spurious acks and branch requests
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i % 2 == 0); imem_rdata = 32'hBAD0_0000 + i;
            PCSrc = 1'b1; pc_target = 32'h2000;
            tick;
            chk("hold_instr", Instr,                32'h1234_5678);
            chk("hold_pc",    PC,                   32'h100);
            chk("hold_req",   {31'b0, imem_req},    32'd0);
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        end
        imem_ack = 1'b0;

        // PC wrap from 0xFFFF_FFFC
        instr_ready = 1'b1; PCSrc = 1'b1; pc_target = 32'hFFFF_FFFC;
        tick;
        instr_ready = 1'b0; PCSrc = 1'b0;
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'hE1A0_0000;
        tick;
        imem_ack = 1'b0;
        chk("top_pc8", PCPlus8, 32'h4);
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("wrap_addr", imem_addr, 32'h0);

        // Move away from RESET_PC, then reset together with ack and ready
        imem_ack = 1'b1; imem_rdata = 32'h11;
        tick;
        imem_ack = 1'b0; instr_ready = 1'b1; PCSrc = 1'b1; pc_target = 32'h40;
        tick;
        instr_ready = 1'b0; PCSrc = 1'b0;
        chk("pre_rst_addr", imem_addr, 32'h40);
        reset = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'h22;
        tick;
        reset = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        chk("rst1_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst1_addr",  imem_addr,            32'h0);
        chk("rst1_instr", Instr,                32'h0);

        // Reset while holding, with ready and a branch pending
        imem_ack = 1'b1; imem_rdata = 32'h33;
        tick;
        imem_ack = 1'b0;
        reset = 1'b1; instr_ready = 1'b1; PCSrc = 1'b1; pc_target = 32'h80; imem_ack = 1'b1;
        tick;
        reset = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0; imem_ack = 1'b0;
        chk("rst2_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst2_addr",  imem_addr,            32'h0);
        chk("rst2_req",   {31'b0, imem_req},    32'd1);

        // No ack for 20 cycles: timeout only when the feature is built in
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("tmo_err", {31'b0, fetch_err}, (TMO_EN && i >= TMO - 1) ? 32'd1 : 32'd0);
            chk("tmo_req", {31'b0, imem_req},  (TMO_EN && i >= TMO - 1) ? 32'd0 : 32'd1);
        end
        imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'h44;
        tick;
        imem_ack = 1'b0; instr_ready = 1'b0;
        chk("tmo_sticky", {31'b0, fetch_err}, TMO_EN ? 32'd1 : 32'd0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("tmo_clr_err", {31'b0, fetch_err}, 32'd0);
        chk("tmo_clr_req", {31'b0, imem_req},  32'd1);
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded by reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: cycles without imem_ack before a fetch error is flagged (used only with FETCH_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  memory read-data-valid strobe.
REQ-008 imem_rdata  input  32  memory read data, valid when imem_ack=1.
REQ-009 Instr  output  32  held instruction word driven to the decode/control stage.
REQ-010 instr_valid  output  1  Instr and PC are valid.
REQ-011 instr_ready  input  1  downstream has completed the held instruction.
REQ-012 PCSrc  input  1  branch/PC-write request from condition logic.
REQ-013 pc_target  input  32  next-PC value when PCSrc=1.
REQ-014 PC  output  32  address of the held instruction.
REQ-015 PCPlus8  output  32  PC+8, the R15 read value.
REQ-016 fetch_err  output  1  sticky fetch timeout flag.

Function
REQ-017 The FSM SHALL have states S_REQ, S_HOLD and S_ERR.
REQ-018 In S_REQ: imem_req=1, imem_addr=PC; imem_req and imem_addr held stable until the cycle imem_ack=1.
REQ-019 S_REQ with imem_ack=1: Instr<=imem_rdata, instr_valid<=1, next state S_HOLD (1-cycle latency from ack to instr_valid).
REQ-020 In S_HOLD: imem_req=0; Instr, PC and instr_valid=1 held unchanged while instr_ready=0.
REQ-021 S_HOLD with instr_ready=1: PC<={pc_target[31:2],2'b00} if PCSrc=1, else PC<=PC+4 (mod 2^32); instr_valid<=0; next state S_REQ.
REQ-022 PCSrc and pc_target SHALL be sampled only in S_HOLD with instr_ready=1; ignored otherwise.
REQ-023 imem_ack outside S_REQ SHALL be ignored.
REQ-024 PC+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-025 PCPlus8 = PC+8 combinationally, modulo 2^32.
REQ-026 Peak throughput: one instruction per two cycles (ack in cycle n, valid n+1, ready n+1, request n+2).
REQ-027 S_ERR: imem_req=0, instr_valid=0, fetch_err=1; exit only by reset.

Reset
REQ-028 reset=1 at a rising edge: state<=S_REQ, PC<=RESET_PC, Instr<=0, instr_valid<=0, fetch_err<=0, timeout counter<=0.
REQ-029 Reset SHALL take priority over imem_ack, instr_ready and PCSrc in the same cycle; an in-flight fetch is abandoned and the first request after reset uses RESET_PC.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: a counter increments each S_REQ cycle without imem_ack and clears on ack or state exit; reaching TIMEOUT_CYCLES transitions to S_ERR.
REQ-031 Macro FETCH_TIMEOUT_EN undefined: no counter, S_ERR unreachable, fetch_err tied 0, S_REQ waits indefinitely.

Verification
REQ-032 Reset, ack with rdata=32'hE3A0_0001 one cycle after request -> imem_addr=0, next cycle Instr=32'hE3A0_0001, instr_valid=1, PC=0, PCPlus8=8.
REQ-033 instr_ready=1, PCSrc=0 at PC=0x10 -> next request imem_addr=0x14; instr_ready=1, PCSrc=1, pc_target=0x103 -> next imem_addr=0x100.
REQ-034 Ack delayed 5 cycles -> imem_req and imem_addr constant over all 5 cycles; instr_valid rises exactly one cycle after ack.
REQ-035 instr_ready low for 4 cycles in S_HOLD, spurious imem_ack pulses -> Instr/PC unchanged, imem_req=0; PC=0xFFFF_FFFC with PCSrc=0 -> next imem_addr=0.
REQ-036 Reset asserted in the same cycle as imem_ack and instr_ready -> instr_valid=0, next request imem_addr=RESET_PC.
REQ-037 With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> fetch_err=1 and imem_req=0 after 16 request cycles, held until reset; without the macro -> imem_req stays 1, fetch_err=0.
